// File: rtl/instr_issue.sv
// rtl/instr_issue.sv - instruction FIFO and IDLE/WAIT issue FSM feeding the control unit
// Optional 16-bit issue counter port enabled by defining INSTR_ISSUE_COUNT_EN.
module instr_issue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        cu_done,
  input  logic        flush,
  output logic [15:0] instr,
  output logic        new_instr,
`ifdef INSTR_ISSUE_COUNT_EN
  output logic        busy,
  output logic [15:0] issue_count
`else
  output logic        busy
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [15:0]     r_mem [DEPTH];
  logic [15:0]     r_instr;
  logic            r_new_instr;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_done;
  logic            w_pop;

  // Occupancy is registered, so a word pushed this edge cannot be popped on the same edge.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid & ~w_full & ~flush;
  assign w_done  = (r_state == S_WAIT) & cu_done & ~r_new_instr;
  assign w_pop   = ~flush & ~w_empty & ((r_state == S_IDLE) | w_done);

  assign in_ready  = ~w_full;
  assign instr     = r_instr;
  assign new_instr = r_new_instr;
  assign busy      = (r_state == S_WAIT);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_instr     <= 16'h0000;
      r_new_instr <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_new_instr <= 1'b0;
    end else if (w_pop) begin
      r_state     <= S_WAIT;
      r_instr     <= r_mem[r_rptr];
      r_new_instr <= 1'b1;
    end else begin
      r_new_instr <= 1'b0;
      if (w_done) begin
        r_state <= S_IDLE;
      end
    end
  end

`ifdef INSTR_ISSUE_COUNT_EN
  logic [15:0] r_issue_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_count <= 16'h0000;
    end else if (w_pop) begin
      r_issue_count <= r_issue_count + 16'h0001;
    end
  end

  assign issue_count = r_issue_count;
`endif

endmodule

// File: tb/tb_instr_issue.sv
// tb/tb_instr_issue.sv - self-checking bench for instr_issue against a queue-based reference model
module tb_instr_issue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        cu_done;
  logic        flush;
  logic [15:0] instr;
  logic        new_instr;
  logic        busy;
`ifdef INSTR_ISSUE_COUNT_EN
  logic [15:0] issue_count;
`endif

  int total;
  int bad;

  logic [15:0] mq[$];
  bit          m_busy;
  bit          m_new;
  logic [15:0] m_instr;
  logic [15:0] m_cnt;

  instr_issue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cu_done    (cu_done),
    .flush      (flush),
    .instr      (instr),
    .new_instr  (new_instr),
`ifdef INSTR_ISSUE_COUNT_EN
    .busy       (busy),
    .issue_count(issue_count)
`else
    .busy       (busy)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic m_reset();
    mq.delete();
    m_busy  = 1'b0;
    m_new   = 1'b0;
    m_instr = 16'h0000;
    m_cnt   = 16'h0000;
  endtask

  // Drive one cycle of inputs, advance the reference model across the edge, settle.
  task automatic step(input bit v, input logic [15:0] d, input bit c, input bit f);
    bit do_pop;
    bit do_push;
    in_valid = v;
    in_data  = d;
    cu_done  = c;
    flush    = f;
    @(posedge clk);
    if (f) begin
      mq.delete();
      m_busy = 1'b0;
      m_new  = 1'b0;
    end else begin
      do_push = v && (mq.size() < DEPTH);
      do_pop  = (mq.size() > 0) && (!m_busy || (c && !m_new));
      if (do_pop) begin
        m_instr = mq.pop_front();
        m_busy  = 1'b1;
        m_new   = 1'b1;
        m_cnt   = m_cnt + 16'h0001;
      end else begin
        if (m_busy && c && !m_new) m_busy = 1'b0;
        m_new = 1'b0;
      end
      if (do_push) mq.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; cu_done = 1'b0; flush = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (instr !== 16'h0000) begin bad++; $display("FAIL rst_instr got=%h exp=0000", instr); end
    total++; if (new_instr !== 1'b0) begin bad++; $display("FAIL rst_new got=%b exp=0", new_instr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
`ifdef INSTR_ISSUE_COUNT_EN
    total++; if (issue_count !== 16'h0000) begin bad++; $display("FAIL rst_count got=%h exp=0000", issue_count); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_latency();
    step(1, 16'h2A05, 0, 0);
    total++; if (new_instr !== 1'b0) begin bad++; $display("FAIL lat_early_new got=%b exp=0", new_instr); end
    step(0, 16'h0000, 0, 0);
    total++; if (instr !== 16'h2A05) begin bad++; $display("FAIL lat_instr got=%h exp=2a05", instr); end
    total++; if (new_instr !== 1'b1) begin bad++; $display("FAIL lat_new got=%b exp=1", new_instr); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL lat_busy got=%b exp=1", busy); end
    step(0, 16'h0000, 0, 0);
    total++; if (new_instr !== 1'b0) begin bad++; $display("FAIL lat_pulse_len got=%b exp=0", new_instr); end
    total++; if (instr !== 16'h2A05) begin bad++; $display("FAIL lat_hold got=%h exp=2a05", instr); end
    step(0, 16'h0000, 1, 0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL lat_idle got=%b exp=0", busy); end
  endtask

  task automatic test_fill();
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'hA003; exp_seq[1] = 16'hA004; exp_seq[2] = 16'hA005; exp_seq[3] = 16'hA006;
    step(1, 16'hA001, 0, 0);
    step(1, 16'hA002, 0, 0);
    step(1, 16'hA003, 0, 0);
    step(1, 16'hA004, 0, 0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready3 got=%b exp=1", in_ready); end
    step(1, 16'hA005, 0, 0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_full got=%b exp=0", in_ready); end
    step(1, 16'hA006, 0, 0);
    step(1, 16'hA006, 0, 0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_held got=%b exp=0", in_ready); end
    total++; if (instr !== 16'hA001) begin bad++; $display("FAIL fill_instr got=%h exp=a001", instr); end
    step(1, 16'hA006, 1, 0);
    total++; if (instr !== 16'hA002) begin bad++; $display("FAIL fullpop_instr got=%h exp=a002", instr); end
    total++; if (new_instr !== 1'b1) begin bad++; $display("FAIL fullpop_new got=%b exp=1", new_instr); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fullpop_ready got=%b exp=1", in_ready); end
    step(1, 16'hA006, 0, 0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL refill_ready got=%b exp=0", in_ready); end
    for (int i = 0; i < 4; i++) begin
      step(0, 16'h0000, 1, 0);
      total++; if (instr !== exp_seq[i] || new_instr !== 1'b1) begin
        bad++; $display("FAIL drain_%0d got=%h/%b exp=%h/1", i, instr, new_instr, exp_seq[i]);
      end
      step(0, 16'h0000, 0, 0);
    end
    step(0, 16'h0000, 1, 0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_idle got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    step(1, 16'h1111, 0, 0);
    step(1, 16'h2222, 0, 0);
    total++; if (instr !== 16'h1111 || new_instr !== 1'b1) begin
      bad++; $display("FAIL b2b_first got=%h/%b exp=1111/1", instr, new_instr);
    end
    step(0, 16'h0000, 1, 0);
    total++; if (instr !== 16'h1111 || new_instr !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL b2b_ignored got=%h/%b/%b exp=1111/0/1", instr, new_instr, busy);
    end
    step(0, 16'h0000, 1, 0);
    total++; if (instr !== 16'h2222 || new_instr !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL b2b_second got=%h/%b/%b exp=2222/1/1", instr, new_instr, busy);
    end
    step(0, 16'h0000, 0, 0);
    step(0, 16'h0000, 1, 0);
    total++; if (busy !== 1'b0 || new_instr !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got=%b/%b exp=0/0", busy, new_instr);
    end
  endtask

  task automatic test_flush();
    step(1, 16'h3001, 0, 0);
    step(1, 16'h3002, 0, 0);
    step(1, 16'h3003, 0, 0);
    step(1, 16'h3004, 0, 0);
    step(0, 16'h0000, 1, 1);
    total++; if (busy !== 1'b0 || new_instr !== 1'b0 || in_ready !== 1'b1 || instr !== 16'h3001) begin
      bad++; $display("FAIL flush_state got=%b/%b/%b/%h exp=0/0/1/3001", busy, new_instr, in_ready, instr);
    end
    step(1, 16'h3005, 0, 1);
    step(0, 16'h0000, 0, 0);
    step(0, 16'h0000, 0, 0);
    total++; if (busy !== 1'b0 || new_instr !== 1'b0 || instr !== 16'h3001) begin
      bad++; $display("FAIL flush_empty got=%b/%b/%h exp=0/0/3001", busy, new_instr, instr);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 16'h4001, 0, 0);
    step(1, 16'h4002, 0, 0);
    step(1, 16'h4003, 0, 0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (instr !== 16'h0000 || new_instr !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_async got=%h/%b/%b/%b exp=0000/0/0/1", instr, new_instr, busy, in_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 16'h0000, 1, 0);
      total++; if (new_instr !== 1'b0 || busy !== 1'b0 || instr !== 16'h0000) begin
        bad++; $display("FAIL rstmid_quiet_%0d got=%b/%b/%h exp=0/0/0000", i, new_instr, busy, instr);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      step(bit'($urandom % 2), 16'($urandom), ($urandom % 3) == 0, ($urandom % 50) == 0);
      total++; if (instr !== m_instr) begin bad++; $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", i, instr, m_instr); end
      total++; if (new_instr !== m_new) begin bad++; $display("FAIL rnd_new cyc=%0d got=%b exp=%b", i, new_instr, m_new); end
      total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, busy, m_busy); end
      total++; if (in_ready !== (mq.size() < DEPTH)) begin
        bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, in_ready, mq.size() < DEPTH);
      end
`ifdef INSTR_ISSUE_COUNT_EN
      total++; if (issue_count !== m_cnt) begin bad++; $display("FAIL rnd_count cyc=%0d got=%h exp=%h", i, issue_count, m_cnt); end
`endif
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_latency();
    test_fill();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
